ucmd_dispatch: RTL and testbench
================================

# ucmd_dispatch

Command front-end for the microcode sequencer. Accepts operation requests over a valid/ready handshake and looks up each opcode's microcode entry point and loop bounds in a programmable table. It launches the sequencer with a one-cycle start pulse, waits for the microcode `done`, and returns a completion response carrying the operation's cycle count. It sits directly upstream of the sequencer and drives its `start_pos`, `upc_start` and `loop_0..loop_4` inputs.

## Interface
- `UINST_ADDR_WIDTH`, 9: width of the microcode address (`upc_start`).
- `LOOP_WIDTH`, 11: width of each loop bound.
- `OP_WIDTH`, 3: opcode width; the table holds 2^OP_WIDTH entries.
- `CYC_WIDTH`, 16: width of the cycle counter.

- `clk`  in  1  clock; one clock; all state changes on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  OP_WIDTH  table entry (opcode) to write.
- `cfg_sel`  in  3  field select: 0 = upc_start, 1..5 = loop_0..loop_4; 6 and 7 are ignored.
- `cfg_data`  in  LOOP_WIDTH  write data; upc_start takes the low UINST_ADDR_WIDTH bits.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high exactly when in IDLE.
- `cmd_op`  in  OP_WIDTH  opcode (table index).
- `cmd_n`  in  LOOP_WIDTH  loop_0 override; 0 selects the table value.
- `start_pos`  out  1  one-cycle launch pulse to the sequencer.
- `upc_start`  out  UINST_ADDR_WIDTH  entry address, registered.
- `loop_0`..`loop_4`  out  LOOP_WIDTH each  loop bounds, registered, held for the whole operation.
- `done`  in  1  end-of-microprogram strobe from the microcode decode (the same net the sequencer sees).
- `busy`  out  1  high in LAUNCH and BUSY.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_op`  out  OP_WIDTH  opcode of the completed command.
- `rsp_cycles`  out  CYC_WIDTH  cycles from the start_pos cycle to the done cycle, inclusive.

## Operation
- Table: 8 entries, each holding upc_start plus loop_0..4. All fields are 0 at reset.
  - Writes apply at the edge and are permitted in any state.
  - Writes never alter outputs already latched.
- FSM states: IDLE, LAUNCH, BUSY, RESP. Reset state is IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`:
  - Latch `cmd_op`, the entry's upc_start and loop_1..4 into the output registers.
  - Latch `loop_0` = (`cmd_n` != 0) ? `cmd_n` : table loop_0.
  - Go to LAUNCH.
  - If `cfg_we` targets the same entry in the accept cycle, the command takes the pre-write value.
- LAUNCH: `start_pos`=1, cycle counter loaded with 1, next state BUSY. A `done` in this cycle is ignored.
- BUSY:
  - Counter increments each cycle and saturates at all-ones; it never wraps.
  - On `done`: `rsp_cycles` = counter+1 (saturated), go to RESP.
- RESP: `rsp_valid`=1, and `rsp_op` and `rsp_cycles` are stable. On `rsp_ready`, go to IDLE.
  - No back-to-back bypass: `cmd_ready` returns one cycle after the response handshake.
- `done` in IDLE or RESP is ignored.
- `upc_start` and `loop_*` keep their last values after completion; they are overwritten only at the next accept.
- The block performs no bound checking. A loop bound of 0 is passed through unchanged; its semantics are the sequencer's.

## Timing
- Reset values (asynchronous):
  - state IDLE, so `cmd_ready`=1.
  - `start_pos`=0, `busy`=0, `rsp_valid`=0.
  - `upc_start`, `loop_0..4`, `rsp_op`, `rsp_cycles` all 0.
- Launch sequence, with the command accepted at edge T:
  - `start_pos` is high for the single cycle after T.
  - The outputs are valid in that same cycle.
  - The sequencer's `upc` equals `upc_start` after edge T+2.
- `done` sampled high in BUSY at edge D makes `rsp_valid` high after D.
- Response timing: minimum accept-to-`rsp_valid` is 3 edges (`done` in the first BUSY cycle), giving `rsp_cycles`=2.
- `start_pos` never asserts in two consecutive cycles.
- Reset asserted mid-operation returns every register to its reset value immediately, including the table.

## Test plan
- Program op 2 (upc_start=0x040, loops 3,4,5,6,7), send cmd_op=2 with cmd_n=0 -> one `start_pos` pulse; upc_start=0x040, loop_0..4 = 3,4,5,6,7.
- Same op with cmd_n=10 -> loop_0=10, the others unchanged. Assert `done` on the 5th BUSY cycle -> `rsp_cycles`=6, `rsp_op`=2.
- `cfg_we` rewriting op 2's loop_1 to 9 in the accept cycle -> loop_1=4. The next command on op 2 -> loop_1=9.
- Hold `rsp_ready`=0 for 20 cycles, with `cmd_valid` high and `done` pulses during that time -> `rsp_valid` and its data stay stable, `cmd_ready`=0, no extra `start_pos`. After the handshake, `cmd_ready`=1 one cycle later.
- With CYC_WIDTH forced to 4, hold BUSY for 30 cycles -> `rsp_cycles`=15, no wrap.
- Drop `rstn` during BUSY -> `busy`=0, `cmd_ready`=1, and a command accepted afterwards sees table values of 0.

Source files
------------

// File: rtl/ucmd_dispatch.sv
// rtl/ucmd_dispatch.sv - microcode sequencer command front-end with programmable entry table
module ucmd_dispatch #(
  parameter int UINST_ADDR_WIDTH = 9,
  parameter int LOOP_WIDTH       = 11,
  parameter int OP_WIDTH         = 3,
  parameter int CYC_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cfg_we,
  input  logic [OP_WIDTH-1:0]         cfg_addr,
  input  logic [2:0]                  cfg_sel,
  input  logic [LOOP_WIDTH-1:0]       cfg_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [OP_WIDTH-1:0]         cmd_op,
  input  logic [LOOP_WIDTH-1:0]       cmd_n,
  output logic                        start_pos,
  output logic [UINST_ADDR_WIDTH-1:0] upc_start,
  output logic [LOOP_WIDTH-1:0]       loop_0,
  output logic [LOOP_WIDTH-1:0]       loop_1,
  output logic [LOOP_WIDTH-1:0]       loop_2,
  output logic [LOOP_WIDTH-1:0]       loop_3,
  output logic [LOOP_WIDTH-1:0]       loop_4,
  input  logic                        done,
  output logic                        busy,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [OP_WIDTH-1:0]         rsp_op,
  output logic [CYC_WIDTH-1:0]        rsp_cycles
);

  localparam int ENTRIES = 1 << OP_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_RESP} state_t;

  state_t state_q, state_d;

  logic [UINST_ADDR_WIDTH-1:0] upc_tbl_q  [ENTRIES];
  logic [LOOP_WIDTH-1:0]       loop_tbl_q [ENTRIES][5];

  logic [UINST_ADDR_WIDTH-1:0] upc_q;
  logic [LOOP_WIDTH-1:0]       loop_q [5];
  logic [OP_WIDTH-1:0]         op_q;
  logic [CYC_WIDTH-1:0]        cnt_q;
  logic [CYC_WIDTH-1:0]        rsp_cycles_q;
  logic [CYC_WIDTH-1:0]        cnt_inc;
  logic                        accept;

  assign accept  = (state_q == S_IDLE) && cmd_valid;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_WIDTH'(1);

  // Table programming; a write in the accept cycle lands after the command has sampled the old entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        upc_tbl_q[i] <= '0;
        for (int j = 0; j < 5; j++) begin
          loop_tbl_q[i][j] <= '0;
        end
      end
    end else if (cfg_we) begin
      if (cfg_sel == 3'd0) begin
        upc_tbl_q[cfg_addr] <= cfg_data[UINST_ADDR_WIDTH-1:0];
      end else if (cfg_sel <= 3'd5) begin
        loop_tbl_q[cfg_addr][cfg_sel - 3'd1] <= cfg_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done is only honoured in BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY:   if (done) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    start_pos = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:   cmd_ready = 1'b1;
      S_LAUNCH: begin
        start_pos = 1'b1;
        busy      = 1'b1;
      end
      S_BUSY:   busy = 1'b1;
      S_RESP:   rsp_valid = 1'b1;
      default:  cmd_ready = 1'b0;
    endcase
  end

  // Launch parameters latched at accept, cycle counter and response capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upc_q        <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      rsp_cycles_q <= '0;
      for (int j = 0; j < 5; j++) begin
        loop_q[j] <= '0;
      end
    end else begin
      if (accept) begin
        op_q      <= cmd_op;
        upc_q     <= upc_tbl_q[cmd_op];
        loop_q[0] <= (cmd_n != '0) ? cmd_n : loop_tbl_q[cmd_op][0];
        for (int j = 1; j < 5; j++) begin
          loop_q[j] <= loop_tbl_q[cmd_op][j];
        end
      end
      if (state_q == S_LAUNCH) begin
        cnt_q <= CYC_WIDTH'(1);
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_inc;
        if (done) begin
          rsp_cycles_q <= cnt_inc;
        end
      end
    end
  end

  assign upc_start  = upc_q;
  assign loop_0     = loop_q[0];
  assign loop_1     = loop_q[1];
  assign loop_2     = loop_q[2];
  assign loop_3     = loop_q[3];
  assign loop_4     = loop_q[4];
  assign rsp_op     = op_q;
  assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_ucmd_dispatch.sv
// tb/tb_ucmd_dispatch.sv - scoreboard bench for ucmd_dispatch with reference table model
module tb_ucmd_dispatch;

  localparam int UW = 9;
  localparam int LW = 11;
  localparam int OW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_we;
  logic [OW-1:0] cfg_addr;
  logic [2:0]    cfg_sel;
  logic [LW-1:0] cfg_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [LW-1:0] cmd_n;
  logic          start_pos;
  logic [UW-1:0] upc_start;
  logic [LW-1:0] loop_0, loop_1, loop_2, loop_3, loop_4;
  logic          done;
  logic          busy;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [OW-1:0] rsp_op;
  logic [CW-1:0] rsp_cycles;

  logic          s_cmd_ready, s_start_pos, s_busy, s_rsp_valid;
  logic [UW-1:0] s_upc_start;
  logic [LW-1:0] s_loop_0, s_loop_1, s_loop_2, s_loop_3, s_loop_4;
  logic [OW-1:0] s_rsp_op;
  logic [3:0]    s_rsp_cycles;

  logic [63:0]   dut_vec;
  assign dut_vec = {upc_start, loop_0, loop_1, loop_2, loop_3, loop_4};

  always #5 clk = ~clk;

  ucmd_dispatch #(.UINST_ADDR_WIDTH(UW), .LOOP_WIDTH(LW), .OP_WIDTH(OW), .CYC_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_n(cmd_n), .start_pos(start_pos), .upc_start(upc_start), .loop_0(loop_0),
    .loop_1(loop_1), .loop_2(loop_2), .loop_3(loop_3), .loop_4(loop_4), .done(done),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_cycles(rsp_cycles)
  );

  ucmd_dispatch #(.UINST_ADDR_WIDTH(UW), .LOOP_WIDTH(LW), .OP_WIDTH(OW), .CYC_WIDTH(4)) dut_sat (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
    .cmd_n(cmd_n), .start_pos(s_start_pos), .upc_start(s_upc_start), .loop_0(s_loop_0),
    .loop_1(s_loop_1), .loop_2(s_loop_2), .loop_3(s_loop_3), .loop_4(s_loop_4), .done(done),
    .busy(s_busy), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_op(s_rsp_op),
    .rsp_cycles(s_rsp_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: what the opcode table should contain after every applied write
  int m_upc [8];
  int m_loop [8][5];

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_upc[i] = 0;
      for (int j = 0; j < 5; j++) m_loop[i][j] = 0;
    end
  endfunction

  function automatic void model_write(input int addr, input int sel, input int data);
    if (sel == 0) m_upc[addr] = data % 512;
    else if (sel <= 5) m_loop[addr][sel-1] = data;
  endfunction

  typedef struct { int op; int cyc; } rsp_t;
  logic [63:0] launch_q [$];
  rsp_t        rsp_q [$];
  logic [63:0] last_launch;
  logic        prev_sp = 1'b0;

  task automatic step();
    @(posedge clk);
    if (rstn && cfg_we) model_write(int'(cfg_addr), int'(cfg_sel), int'(cfg_data));
    #1;
  endtask

  task automatic cfg_write(input int addr, input int sel, input int data);
    cfg_we = 1'b1; cfg_addr = OW'(addr); cfg_sel = 3'(sel); cfg_data = LW'(data);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rand_cfg();
    cfg_we   = ($urandom_range(0, 3) == 0);
    cfg_addr = OW'($urandom);
    cfg_sel  = 3'($urandom);
    cfg_data = LW'($urandom);
  endtask

  // One full command: accept, hold BUSY for k cycles, stall the response rdly cycles
  task automatic run_cmd(input int op, input int n, input int k, input int rdly,
                         input bit collide, input int csel, input int cdata, input bit rnd_cfg);
    int waitc;
    int l0;
    waitc = 0;
    while (!cmd_ready && waitc < 60) begin step(); waitc++; end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    l0 = (n != 0) ? n : m_loop[op][0];
    last_launch = {UW'(m_upc[op]), LW'(l0), LW'(m_loop[op][1]), LW'(m_loop[op][2]),
                   LW'(m_loop[op][3]), LW'(m_loop[op][4])};
    launch_q.push_back(last_launch);
    cmd_valid = 1'b1; cmd_op = OW'(op); cmd_n = LW'(n);
    if (collide) begin
      cfg_we = 1'b1; cfg_addr = OW'(op); cfg_sel = 3'(csel); cfg_data = LW'(cdata);
    end else begin
      cfg_we = 1'b0;
    end
    step();
    cmd_valid = 1'b0; cfg_we = 1'b0; cmd_op = OW'($urandom); cmd_n = LW'($urandom);
    check("launch_status", {start_pos, busy, cmd_ready}, 3'b110);
    done = 1'($urandom_range(0, 1));
    if (rnd_cfg) rand_cfg();
    for (int i = 1; i <= k; i++) begin
      step();
      check("busy_status", {busy, rsp_valid, start_pos, cmd_ready}, 4'b1000);
      done = (i == k);
      if (rnd_cfg) rand_cfg();
    end
    rsp_q.push_back('{op, k + 1});
    step();
    done = 1'b0; cfg_we = 1'b0;
    check("rsp_valid_after_done", {rsp_valid, busy}, 2'b10);
    for (int i = 0; i < rdly; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      done      = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0; done = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    check("outputs_held", dut_vec, last_launch);
  endtask

  // Monitor: pops launch and response expectations whenever the DUT presents them
  always @(negedge clk) begin
    if (rstn) begin
      if (start_pos) begin
        check("start_pos_gap", prev_sp, 1'b0);
        if (launch_q.size() == 0) check("launch_unexpected", start_pos, 1'b0);
        else check("launch_vals", dut_vec, launch_q.pop_front());
      end
      prev_sp = start_pos;
      if (rsp_valid) begin
        check("cmd_ready_in_resp", {cmd_ready, start_pos}, 2'b00);
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          check("rsp_op", rsp_op, rsp_q[0].op);
          check("rsp_cycles", rsp_cycles, rsp_q[0].cyc);
          check("rsp_cycles_sat4", {s_rsp_valid, s_rsp_cycles},
                {1'b1, 4'((rsp_q[0].cyc > 15) ? 15 : rsp_q[0].cyc)});
          if (rsp_ready) void'(rsp_q.pop_front());
        end
      end
    end else begin
      prev_sp = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_n = '0; done = 1'b0; rsp_ready = 1'b0;
    model_clear();
    step(); step();
    check("reset_status", {cmd_ready, start_pos, busy, rsp_valid}, 4'b1000);
    check("reset_launch_regs", dut_vec, 64'd0);
    check("reset_rsp_regs", {rsp_op, rsp_cycles}, 19'd0);
    rstn = 1'b1;
    step();
    check("post_reset_status", {cmd_ready, start_pos, busy, rsp_valid}, 4'b1000);

    // Program op 2 and launch it with the table loop_0
    cfg_write(2, 0, 'h040);
    for (int s = 1; s <= 5; s++) cfg_write(2, s, s + 2);
    cfg_write(2, 6, 'h7FF);
    cfg_write(2, 7, 'h123);
    run_cmd(2, 0, 3, 0, 1'b0, 0, 0, 1'b0);
    check("tp_table_values", dut_vec, {9'h040, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7});

    // cmd_n override, done on the 5th BUSY cycle
    run_cmd(2, 10, 5, 1, 1'b0, 0, 0, 1'b0);
    check("tp_override", dut_vec, {9'h040, 11'd10, 11'd4, 11'd5, 11'd6, 11'd7});
    check("tp_cycles6", {rsp_op, rsp_cycles}, {3'd2, 16'd6});

    // Write to the same entry in the accept cycle
    run_cmd(2, 0, 2, 0, 1'b1, 2, 9, 1'b0);
    check("tp_collide_old", loop_1, 11'd4);
    run_cmd(2, 0, 1, 0, 1'b0, 0, 0, 1'b0);
    check("tp_collide_new", loop_1, 11'd9);
    check("tp_min_cycles", rsp_cycles, 16'd2);

    // Long response stall with command and done noise
    run_cmd(2, 0, 4, 20, 1'b0, 0, 0, 1'b0);

    // 30 BUSY cycles: 16-bit counter gives 31, 4-bit copy saturates at 15
    run_cmd(5, 0, 30, 2, 1'b0, 0, 0, 1'b1);
    check("tp_sat4", {rsp_cycles, s_rsp_cycles}, {16'd31, 4'd15});

    // Reset during BUSY
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_n = '0;
    launch_q.push_back({UW'(m_upc[2]), LW'(m_loop[2][0]), LW'(m_loop[2][1]),
                        LW'(m_loop[2][2]), LW'(m_loop[2][3]), LW'(m_loop[2][4])});
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("pre_reset_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("midop_reset_status", {busy, cmd_ready, rsp_valid, start_pos}, 4'b0100);
    check("midop_reset_regs", dut_vec, 64'd0);
    model_clear();
    step();
    rstn = 1'b1;
    step();
    run_cmd(2, 0, 2, 0, 1'b0, 0, 0, 1'b0);
    check("tp_table_cleared", dut_vec, 64'd0);

    // Randomized traffic with table writes between and during commands
    for (int t = 0; t < 40; t++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      run_cmd($urandom_range(0, 7),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2047) : 0,
              $urandom_range(1, 24), $urandom_range(0, 5),
              1'($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom,
              1'($urandom_range(0, 1)));
    end

    step(); step();
    check("launch_queue_drained", launch_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
